// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared address map, MMIO register offsets and init FSM encoding.
package data_mem_responder_pkg;
  localparam logic [63:0] DMR_BASE_DATA  = 64'h0000_0000_1001_0000;
  localparam logic [63:0] DMR_BASE_MMIO  = 64'h0000_0000_FF20_0000;
  localparam int          DMR_DATA_DEPTH = 512;
  localparam logic [63:0] MMIO_SPAN      = 64'd24;
  localparam logic [1:0]  MMIO_CYCLES    = 2'd0;
  localparam logic [1:0]  MMIO_STORES    = 2'd1;
  localparam logic [1:0]  MMIO_STATUS    = 2'd2;
  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} init_state_e;
endpackage

// File: rtl/dmem_bytelane_ram.sv
// dmem_bytelane_ram: DEPTH x 64 RAM, async read, one byte-lane write port shared by clear and bus.
module dmem_bytelane_ram #(
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic          bus_we_i,
  input  logic [AW-1:0] bus_addr_i,
  input  logic [7:0]    bus_be_i,
  input  logic [63:0]   bus_wdata_i,
  output logic [63:0]   rdata_o
);
  logic [63:0] mem [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    be;
  logic [63:0]   wdata;
  // The clear sequence owns the write port whenever it is running.
  always_comb begin
    we    = clr_en_i | bus_we_i;
    waddr = clr_en_i ? clr_addr_i : bus_addr_i;
    be    = clr_en_i ? 8'hFF : bus_be_i;
    wdata = clr_en_i ? 64'd0 : bus_wdata_i;
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++)
      if (we && be[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
  end
  assign rdata_o = mem[bus_addr_i];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: zero-wait-state data RAM plus CYCLES/STORES/STATUS MMIO window,
// with a post-reset clear sequence and a sticky decode-error flag.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter logic [63:0] BASE_DATA  = DMR_BASE_DATA,
  parameter int          DATA_DEPTH = DMR_DATA_DEPTH,
  parameter logic [63:0] BASE_MMIO  = DMR_BASE_MMIO
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReadEnable,
  input  logic        iWriteEnable,
  input  logic [63:0] iAddress,
  input  logic [63:0] iWriteData,
  input  logic [7:0]  iByteEnable,
  output logic [63:0] oReadData,
  output logic        oReady,
  output logic        oError
);
  localparam int          AW        = $clog2(DATA_DEPTH);
  localparam logic [63:0] RAM_BYTES = 64'(DATA_DEPTH) << 3;
  localparam logic [AW-1:0] LAST_IDX = AW'(DATA_DEPTH - 1);
  init_state_e   state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [63:0]   cycles_q, cycles_d;
  logic [63:0]   stores_q, stores_d;
  logic          error_q, error_d;
  logic [63:0]   ram_off, mmio_off, ram_rdata;
  logic [AW-1:0] word_idx;
  logic [1:0]    mmio_sel;
  logic          ram_hit, mmio_hit, ready, bus_we, clr_en;
  logic          err_set, err_clr;
  // Offsets are taken before the range test so the low 3 address bits never affect the decode.
  always_comb begin
    ram_off  = iAddress - BASE_DATA;
    mmio_off = iAddress - BASE_MMIO;
    ram_hit  = (iAddress >= BASE_DATA) && (ram_off < RAM_BYTES);
    mmio_hit = (iAddress >= BASE_MMIO) && (mmio_off < MMIO_SPAN);
    word_idx = ram_off[AW+2:3];
    mmio_sel = mmio_off[4:3];
  end
  assign ready   = (state_q == ST_READY);
  assign clr_en  = (state_q == ST_CLEAR) && !iRST;
  assign bus_we  = iWriteEnable && ram_hit && ready && !iRST;
  assign err_set = (iReadEnable || iWriteEnable) && !ram_hit && !mmio_hit;
  assign err_clr = iWriteEnable && mmio_hit && (mmio_sel == MMIO_STATUS)
                   && iByteEnable[0] && iWriteData[0];
  always_comb begin
    state_d   = (state_q == ST_CLEAR && clr_idx_q == LAST_IDX) ? ST_READY : state_q;
    clr_idx_d = (state_q == ST_CLEAR) ? clr_idx_q + 1'b1 : clr_idx_q;
  end
  always_comb begin
    cycles_d = cycles_q + 64'd1;
    stores_d = stores_q + 64'(bus_we);
    error_d  = err_set | (error_q & ~err_clr);
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      cycles_q  <= '0;
      stores_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      cycles_q  <= cycles_d;
      stores_q  <= stores_d;
      error_q   <= error_d;
    end
  end
  dmem_bytelane_ram #(.DEPTH(DATA_DEPTH)) u_ram (
    .clk         (iCLK),
    .clr_en_i    (clr_en),
    .clr_addr_i  (clr_idx_q),
    .bus_we_i    (bus_we),
    .bus_addr_i  (word_idx),
    .bus_be_i    (iByteEnable),
    .bus_wdata_i (iWriteData),
    .rdata_o     (ram_rdata)
  );
  // Async RAM read returns the pre-write word when a write hits the same index this cycle.
  always_comb begin
    oReadData = !iReadEnable ? 64'd0
              : ram_hit ? (ready ? ram_rdata : 64'd0)
              : !mmio_hit ? 64'd0
              : (mmio_sel == MMIO_CYCLES) ? cycles_q
              : (mmio_sel == MMIO_STORES) ? stores_q
              : (mmio_sel == MMIO_STATUS) ? {62'd0, ready, error_q}
              : 64'd0;
  end
  assign oReady = ready;
  assign oError = error_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and randomized checks against a behavioural model of the responder.
module tb_data_mem_responder;
  localparam logic [63:0] BD    = 64'h0000_0000_1001_0000;
  localparam logic [63:0] BM    = 64'h0000_0000_FF20_0000;
  localparam int          DEPTH = 512;
  logic        clk = 1'b0;
  logic        rst, re, we;
  logic [63:0] addr, wd;
  logic [7:0]  be;
  logic [63:0] rd;
  logic        rdy, err;
  always #5 clk = ~clk;
  data_mem_responder dut (
    .iCLK(clk), .iRST(rst), .iReadEnable(re), .iWriteEnable(we), .iAddress(addr),
    .iWriteData(wd), .iByteEnable(be), .oReadData(rd), .oReady(rdy), .oError(err)
  );
  logic [63:0] m_mem [DEPTH];
  logic [63:0] m_cyc, m_st, mask;
  logic        m_err, bad, clr, rdy_now;
  int          m_since;
  bit          force_cyc;
  bit          cmp_en;
  logic [2:0]  lit_v;
  logic [63:0] lit_rd;
  logic        lit_rdy, lit_err;
  string       lit_tag;
  int          checks = 0;
  int          errors = 0;
  function automatic bit in_ram(logic [63:0] a);
    return a >= BD && a < BD + 64'd4096;
  endfunction
  function automatic bit in_mmio(logic [63:0] a);
    return a >= BM && a < BM + 64'd24;
  endfunction
  function automatic logic [63:0] m_read();
    if (!re) return 64'd0;
    if (in_ram(addr)) return (m_since >= DEPTH) ? m_mem[int'((addr - BD) >> 3)] : 64'd0;
    if (in_mmio(addr)) begin
      case ((addr - BM) >> 3)
        64'd0:   return force_cyc ? '1 : m_cyc;
        64'd1:   return m_st;
        default: return {62'd0, m_since >= DEPTH, m_err};
      endcase
    end
    return 64'd0;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_cyc = 0; m_st = 0; m_err = 0; m_since = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 64'd0;
    end else begin
      rdy_now = m_since >= DEPTH;
      bad = (re || we) && !in_ram(addr) && !in_mmio(addr);
      clr = we && in_mmio(addr) && ((addr - BM) >> 3) == 64'd2 && be[0] && wd[0];
      if (we && in_ram(addr) && rdy_now) begin
        for (int k = 0; k < 8; k++) mask[8*k +: 8] = be[k] ? 8'hFF : 8'h00;
        m_mem[int'((addr - BD) >> 3)] = (m_mem[int'((addr - BD) >> 3)] & ~mask) | (wd & mask);
        m_st = m_st + 1;
      end
      m_err = bad | (m_err & !clr);
      m_cyc = (force_cyc ? '1 : m_cyc) + 64'd1;
      if (m_since < DEPTH) m_since++;
    end
  end
  task automatic check(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (cmp_en) begin
      check("rdata", rd, m_read());
      check("ready", 64'(rdy), 64'(m_since >= DEPTH));
      check("error", 64'(err), 64'(m_err));
      if (lit_v[0]) begin
        check({lit_tag, "_rd"}, rd, lit_rd);
        check({lit_tag, "_rd_model"}, m_read(), lit_rd);
      end
      if (lit_v[1]) check({lit_tag, "_ready"}, 64'(rdy), 64'(lit_rdy));
      if (lit_v[2]) check({lit_tag, "_error"}, 64'(err), 64'(lit_err));
    end
  end
  task automatic drive(bit r, bit w, logic [63:0] a, logic [63:0] d, logic [7:0] b);
    re = r; we = w; addr = a; wd = d; be = b;
  endtask
  task automatic tick();
    @(negedge clk); #1;
    lit_v = 3'b000;
    @(posedge clk); #1;
  endtask
  task automatic exp_rd(string t, logic [63:0] v);
    lit_tag = t; lit_v[0] = 1'b1; lit_rd = v;
  endtask
  task automatic exp_rdy(string t, logic v);
    lit_tag = t; lit_v[1] = 1'b1; lit_rdy = v;
  endtask
  task automatic exp_err(string t, logic v);
    lit_tag = t; lit_v[2] = 1'b1; lit_err = v;
  endtask
  initial begin
    rst = 1'b1; cmp_en = 1'b0; lit_v = 3'b000; force_cyc = 1'b0;
    drive(0, 0, 64'd0, 64'd0, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0; cmp_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 1, BD + 64'(8 * $urandom_range(0, 511)), {$urandom, $urandom}, 8'hFF);
      tick();
    end
    rst = 1'b1;
    drive(0, 1, BD, '1, 8'hFF);
    exp_rdy("mid_clear_reset", 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 16) drive(1, 1, BD + 64'(8 * i), {$urandom, $urandom}, 8'hFF);
      else if (i == 20) begin drive(1, 0, BM + 64'd8, 0, 0); exp_rd("stores_in_clear", 64'd0); end
      else drive(0, 0, 64'd0, 64'd0, 8'h00);
      if (i == 0) exp_rdy("clear_first", 1'b0);
      if (i == DEPTH - 1) exp_rdy("clear_last", 1'b0);
      tick();
    end
    drive(1, 0, BD, 0, 0); exp_rd("ready_rise", 64'd0); exp_rdy("ready_rise", 1'b1); tick();
    drive(1, 0, BM + 64'd8, 0, 0); exp_rd("stores_after_clear", 64'd0); tick();
    drive(0, 1, BD + 64'h8, 64'h1122334455667788, 8'hFF); tick();
    drive(0, 1, BD + 64'hC, 64'hAAAAAAAAAAAAAAAA, 8'h0F); tick();
    drive(1, 0, BD + 64'h8, 0, 0); exp_rd("byte_lane", 64'h11223344AAAAAAAA); tick();
    drive(1, 0, BM + 64'd8, 0, 0); exp_rd("stores_two", 64'd2); tick();
    drive(1, 1, BD + 64'h10, 64'hDEADBEEF00000000, 8'hFF); exp_rd("same_word_old", 64'd0); tick();
    drive(1, 0, BD + 64'h10, 0, 0); exp_rd("same_word_new", 64'hDEADBEEF00000000); tick();
    drive(1, 0, 64'd0, 0, 0); exp_rd("bad_read", 64'd0); exp_err("bad_read", 1'b0); tick();
    drive(1, 0, BM + 64'h10, 0, 0); exp_rd("status_err", 64'd3); exp_err("status_err", 1'b1); tick();
    drive(0, 1, BM + 64'h10, 64'd1, 8'h01); tick();
    drive(1, 0, BM + 64'h10, 0, 0); exp_rd("status_clr", 64'd2); exp_err("status_clr", 1'b0); tick();
    force dut.err_clr = 1'b1;
    drive(1, 0, 64'h8000, 0, 0); tick();
    release dut.err_clr;
    drive(0, 0, 64'd0, 0, 0); exp_err("set_over_clear", 1'b1); tick();
    drive(0, 1, BM + 64'h10, 64'd1, 8'h01); tick();
    drive(0, 1, BD + 64'hFF8, 64'h0123456789ABCDEF, 8'hFF); tick();
    drive(1, 0, BD + 64'hFF8, 0, 0); exp_rd("last_word", 64'h0123456789ABCDEF); exp_err("last_word", 1'b0); tick();
    drive(0, 1, BD + 64'h1000, 64'd5, 8'hFF); tick();
    drive(1, 0, BM + 64'h10, 0, 0); exp_err("past_end", 1'b1); exp_rd("past_end", 64'd3); tick();
    drive(0, 1, BM + 64'h10, 64'd1, 8'h01); tick();
    drive(1, 0, BM, 0, 0);
    force_cyc = 1'b1;
    force dut.cycles_q = '1;
    exp_rd("cycles_max", '1);
    @(negedge clk); #1;
    release dut.cycles_q;
    lit_v = 3'b000;
    @(posedge clk); #1;
    force_cyc = 1'b0;
    exp_rd("cycles_wrap", 64'd0); tick();
    for (int i = 0; i < 4000; i++) begin
      int kind;
      logic [63:0] a;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1:       a = BD + 64'($urandom_range(0, 63));
        2, 3, 4, 5: a = BD + 64'($urandom_range(0, 4095));
        6, 7:       a = BM + 64'($urandom_range(0, 23));
        8: begin
          case ($urandom_range(0, 3))
            0: a = BD - 64'd1;
            1: a = BD + 64'd4096;
            2: a = BM + 64'd24;
            default: a = BM - 64'd8;
          endcase
        end
        default: a = {$urandom, $urandom};
      endcase
      rst = ($urandom_range(0, 799) == 0);
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, {$urandom, $urandom}, 8'($urandom));
      tick();
    end
    rst = 1'b0;
    drive(0, 0, 64'd0, 64'd0, 8'h00);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
